// File: rtl/serial_tx_shifter_pkg.sv
`default_nettype none
// ============================================================================
// serial_tx_pkg : frame state encoding and line levels for serial_tx_shifter
// Revision      : 1.0
// ============================================================================
package serial_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/serial_tx_shifter_if.sv
`default_nettype none
// ============================================================================
// serial_tx_shifter_if : load handshake and serial line bundle
// Revision             : 1.0
// ============================================================================
interface serial_tx_shifter_if #(
  parameter int NBITS = 4
);
  logic [NBITS-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  modport master (
    output data_in, load_valid,
    input  load_ready, ser_out, ser_valid, busy, done
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, ser_out, ser_valid, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/serial_tx_shifter_bit_period.sv
`default_nettype none
// ============================================================================
// bit_period_counter : divides clk_2 into serial bit periods, tick on last cycle
// Revision           : 1.0
// ============================================================================
module bit_period_counter #(
  parameter int BIT_CYCLES = 1
) (
  input  wire  clk_2,
  input  wire  reset,
  input  wire  clear,
  output logic tick
);
  localparam int              c_cnt_w = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(BIT_CYCLES - 1);

  logic [c_cnt_w-1:0] r_count;

  // With a single cycle per bit the tick wraps the counter every cycle, pinning it at 0
  always_ff @(posedge clk_2) begin
    if (reset || clear || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + c_cnt_w'(1);
    end
  end

  assign tick = (r_count == c_last);
endmodule
`default_nettype wire

// File: rtl/serial_tx_shifter.sv
`default_nettype none
// ============================================================================
// serial_tx_shifter : parallel-in, framed serial-out transmitter (start, LSB first, stop)
// Revision          : 1.0
// ============================================================================
module serial_tx_shifter
  import serial_tx_pkg::*;
#(
  parameter int NBITS      = 4,
  parameter int BIT_CYCLES = 1
) (
  input wire                 clk_2,
  input wire                 reset,
  serial_tx_shifter_if.slave bus
);
  localparam int                  c_bcnt_w   = $clog2(NBITS + 1);
  localparam logic [c_bcnt_w-1:0] c_last_bit = c_bcnt_w'(NBITS - 1);

  tx_state_t           r_state;
  tx_state_t           w_state_next;
  logic [NBITS-1:0]    r_shreg;
  logic [c_bcnt_w-1:0] r_bit_cnt;
  logic                r_done;
  logic                w_tick;
  logic                w_accept;
  logic                w_state_change;
  logic                w_data_tick;
  logic                w_line;

  bit_period_counter #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_period (
    .clk_2 (clk_2),
    .reset (reset),
    .clear (w_state_change),
    .tick  (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_line       = LINE_IDLE;
    unique case (r_state)
      S_IDLE: begin
        if (bus.load_valid) w_state_next = S_START;
      end
      S_START: begin
        w_line = LINE_START;
        if (w_tick) w_state_next = S_DATA;
      end
      S_DATA: begin
        w_line = r_shreg[0];
        if (w_tick && (r_bit_cnt == c_last_bit)) w_state_next = S_STOP;
      end
      S_STOP: begin
        w_line = LINE_STOP;
        if (w_tick) w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_accept       = (r_state == S_IDLE) && bus.load_valid;
  assign w_state_change = (w_state_next != r_state);
  assign w_data_tick    = (r_state == S_DATA) && w_tick;

  // Both counters restart on every state change so each phase begins on a fresh bit period
  always_ff @(posedge clk_2) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == S_STOP) && w_tick;
      if (w_accept) begin
        r_shreg <= bus.data_in;
      end else if (w_data_tick) begin
        r_shreg <= r_shreg >> 1;
      end
      if (w_state_change) begin
        r_bit_cnt <= '0;
      end else if (w_data_tick) begin
        r_bit_cnt <= r_bit_cnt + c_bcnt_w'(1);
      end
    end
  end

  assign bus.ser_out    = w_line;
  assign bus.ser_valid  = (r_state == S_DATA);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.load_ready = (r_state == S_IDLE);
  assign bus.done       = r_done;
endmodule
`default_nettype wire

// File: tb/tb_serial_tx_shifter.sv
`default_nettype none
// ============================================================================
// tb_serial_tx_shifter : frame-level model bench for serial_tx_shifter (1 and 3 cycles/bit)
// Revision             : 1.0
// ============================================================================
module tb_serial_tx_shifter;
  localparam int NB = 4;

  logic clk_2 = 1'b0;
  logic reset;
  always #5 clk_2 = ~clk_2;

  serial_tx_shifter_if #(.NBITS(NB)) bus1 ();
  serial_tx_shifter_if #(.NBITS(NB)) bus3 ();

  serial_tx_shifter #(.NBITS(NB), .BIT_CYCLES(1)) dut1 (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus1.slave)
  );

  serial_tx_shifter #(.NBITS(NB), .BIT_CYCLES(3)) dut3 (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus3.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check4(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic checki(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic bit_at(input logic [31:0] v, input int i);
    logic [31:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Frame model: a frame is (NB+2) slots of bcs[k] cycles; slot 0 start, 1..NB data, last stop
  int          bcs[2] = '{1, 3};
  bit          m_active[2] = '{0, 0};
  bit          m_done[2]   = '{0, 0};
  int          m_idx[2]    = '{0, 0};
  logic [31:0] m_word[2];
  bit          model_live = 0;

  function automatic void model_step(input int k, input logic lv, input logic [NB-1:0] d);
    if (reset) begin
      m_active[k] = 0;
      m_idx[k]    = 0;
      m_done[k]   = 0;
    end else begin
      m_done[k] = 0;
      if (m_active[k]) begin
        m_idx[k]++;
        if (m_idx[k] == (NB + 2) * bcs[k]) begin
          m_active[k] = 0;
          m_done[k]   = 1;
        end
      end else if (lv) begin
        m_active[k] = 1;
        m_idx[k]    = 0;
        m_word[k]   = 32'(d);
      end
    end
  endfunction

  // {ser_out, ser_valid, busy, load_ready, done}
  function automatic logic [4:0] model_out(input int k);
    int   slot;
    logic line;
    logic val;
    if (!m_active[k]) return {1'b1, 1'b0, 1'b0, 1'b1, m_done[k]};
    slot = m_idx[k] / bcs[k];
    if (slot == 0)       line = 1'b0;
    else if (slot <= NB) line = bit_at(m_word[k], slot - 1);
    else                 line = 1'b1;
    val = (slot >= 1) && (slot <= NB);
    return {line, val, 1'b1, 1'b0, 1'b0};
  endfunction

  always @(posedge clk_2) begin
    if (reset) model_live = 1;
    model_step(0, bus1.load_valid, bus1.data_in);
    model_step(1, bus3.load_valid, bus3.data_in);
  end

  always @(negedge clk_2) begin
    logic [4:0] e1;
    logic [4:0] e3;
    if (model_live) begin
      e1 = model_out(0);
      e3 = model_out(1);
      check1("bc1 ser_out",    bus1.ser_out,    e1[4]);
      check1("bc1 ser_valid",  bus1.ser_valid,  e1[3]);
      check1("bc1 busy",       bus1.busy,       e1[2]);
      check1("bc1 load_ready", bus1.load_ready, e1[1]);
      check1("bc1 done",       bus1.done,       e1[0]);
      check1("bc3 ser_out",    bus3.ser_out,    e3[4]);
      check1("bc3 ser_valid",  bus3.ser_valid,  e3[3]);
      check1("bc3 busy",       bus3.busy,       e3[2]);
      check1("bc3 load_ready", bus3.load_ready, e3[1]);
      check1("bc3 done",       bus3.done,       e3[0]);
    end
  end

  // Right-shift receiver: serial data enters at the MSB
  logic [NB-1:0] rx = '0;
  always @(posedge clk_2) begin
    if (bus1.ser_valid) rx <= {bus1.ser_out, rx[NB-1:1]};
  end

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic wait_done1(input int budget, input string name);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_2);
      if (bus1.done === 1'b1) seen = 1;
      else step();
    end
    n_checks++;
    if (seen) n_pass++;
    else $display("FAIL %s: no done pulse within %0d cycles", name, budget);
  endtask

  initial begin
    logic [31:0] t1_line;
    logic [31:0] t1_valid;
    logic [31:0] t2_line;
    logic [31:0] t3_order;
    logic [31:0] t4_line;
    logic [4:0]  e;
    logic        t3_bits[$];
    int          d_first;
    int          d_second;
    int          n_done;

    t1_line  = 32'b110110;
    t1_valid = 32'b011110;
    t2_line  = 32'b000000111111000111;
    t3_order = 32'b1001;
    t4_line  = 32'b1111_1000_0110_0010;

    reset           = 1'b1;
    bus1.load_valid = 1'b0;
    bus1.data_in    = '0;
    bus3.load_valid = 1'b0;
    bus3.data_in    = '0;
    repeat (2) @(posedge clk_2);
    #1 reset = 1'b0;

    @(negedge clk_2);
    check1("reset ser_out",    bus1.ser_out,    1'b1);
    check1("reset ser_valid",  bus1.ser_valid,  1'b0);
    check1("reset busy",       bus1.busy,       1'b0);
    check1("reset load_ready", bus1.load_ready, 1'b1);
    check1("reset done",       bus1.done,       1'b0);

    // Basic frame, one cycle per bit
    step();
    bus1.data_in    = 4'b1011;
    bus1.load_valid = 1'b1;
    step();
    bus1.load_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_2);
      e = model_out(0);
      check1("t1 line",       bus1.ser_out,   bit_at(t1_line, c - 1));
      check1("t1 valid",      bus1.ser_valid, bit_at(t1_valid, c - 1));
      check1("t1 model line", e[4],           bit_at(t1_line, c - 1));
      check1("t1 no done",    bus1.done,      1'b0);
      step();
    end
    @(negedge clk_2);
    check1("t1 done",       bus1.done, 1'b1);
    check1("t1 model done", model_out(0) == 5'b10011, 1'b1);
    check4("t1 rx word",    rx,        4'b1011);
    step();
    @(negedge clk_2);
    check1("t1 done single", bus1.done, 1'b0);

    // Slow bit rate, three cycles per bit
    step();
    bus3.data_in    = 4'b0110;
    bus3.load_valid = 1'b1;
    step();
    bus3.load_valid = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk_2);
      e = model_out(1);
      check1("t2 line",       bus3.ser_out, bit_at(t2_line, 18 - c));
      check1("t2 model line", e[4],         bit_at(t2_line, 18 - c));
      check1("t2 busy",       bus3.busy,    1'b1);
      step();
    end
    @(negedge clk_2);
    check1("t2 idle busy", bus3.busy, 1'b0);
    check1("t2 done",      bus3.done, 1'b1);

    // New word offered during the whole frame is only taken in the done cycle
    step();
    bus1.data_in    = 4'b1001;
    bus1.load_valid = 1'b1;
    step();
    bus1.data_in = 4'b1111;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_2);
      if (bus1.ser_valid) t3_bits.push_back(bus1.ser_out);
      step();
    end
    @(negedge clk_2);
    check1("t3 done",  bus1.done, 1'b1);
    checki("t3 nbits", t3_bits.size(), 4);
    for (int i = 0; i < 4 && i < t3_bits.size(); i++) begin
      check1("t3 bit order", t3_bits[i], bit_at(t3_order, i));
    end
    check4("t3 rx first", rx, 4'b1001);
    step();
    bus1.load_valid = 1'b0;
    @(negedge clk_2);
    check1("t3 second busy", bus1.busy, 1'b1);
    step();
    wait_done1(12, "t3 second frame");
    check4("t3 rx second", rx, 4'b1111);
    step();

    // Back-to-back frames with load_valid held high
    bus1.data_in    = 4'b0001;
    bus1.load_valid = 1'b1;
    step();
    bus1.data_in = 4'b1000;
    d_first  = -1;
    d_second = -1;
    n_done   = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk_2);
      check1("t4 line", bus1.ser_out, bit_at(t4_line, c - 1));
      if (bus1.done === 1'b1) begin
        n_done++;
        if (d_first < 0) d_first = c;
        else d_second = c;
      end
      step();
      if (c == 7) bus1.load_valid = 1'b0;
    end
    checki("t4 done count",   n_done, 2);
    checki("t4 done spacing", d_second - d_first, 7);
    check4("t4 rx second",    rx, 4'b1000);

    // Reset during the third data bit
    bus1.data_in    = 4'b1010;
    bus1.load_valid = 1'b1;
    step();
    bus1.load_valid = 1'b0;
    step();
    step();
    step();
    reset = 1'b1;
    @(negedge clk_2);
    check1("t5 third bit valid", bus1.ser_valid, 1'b1);
    check1("t5 third bit line",  bus1.ser_out,   1'b0);
    step();
    reset = 1'b0;
    @(negedge clk_2);
    check1("t5 ser_out",    bus1.ser_out,    1'b1);
    check1("t5 ser_valid",  bus1.ser_valid,  1'b0);
    check1("t5 busy",       bus1.busy,       1'b0);
    check1("t5 load_ready", bus1.load_ready, 1'b1);
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      @(negedge clk_2);
      if (bus1.done === 1'b1) n_done++;
    end
    checki("t5 no done after abort", n_done, 0);

    // Loopback of every 4-bit value
    for (int v = 0; v < 16; v++) begin
      step();
      bus1.data_in    = 4'(v);
      bus1.load_valid = 1'b1;
      step();
      bus1.load_valid = 1'b0;
      wait_done1(12, "t6 frame");
      check4("t6 loopback", rx, 4'(v));
    end

    repeat (3) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
